status_tx: RTL and testbench

//  FPGA->CPU status word transmitter; counterpart of the CPU->FPGA command decoder on the same 32-bit GPIO word format.

---
 rtl/status_tx_pkg.sv | 45 ++++
 rtl/status_tx_if.sv | 24 ++
 rtl/status_tx_sync_2ff.sv | 24 ++
 rtl/status_tx.sv | 173 +++++++++++++++++
 tb/tb_status_tx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/status_tx_pkg.sv
// Shared word-format definitions for the CPU<->FPGA GPIO status/command link.
// The command decoder imports the same field positions and addresses.
package status_tx_pkg;

   localparam int WORD_W    = 32;
   localparam int ADDR_W    = 6;
   localparam int PAYLOAD_W = 24;
   localparam int DROP_W    = 8;

   localparam int FLAG_BIT   = 31;
   localparam int ADDR_HI    = 30;
   localparam int ADDR_LO    = 25;
   localparam int CTRL_BIT   = 24;
   localparam int PAYLOAD_HI = 23;
   localparam int PAYLOAD_LO = 0;

   localparam logic [ADDR_W-1:0] ADDR_DONE = 6'b000000;
   localparam logic [ADDR_W-1:0] ADDR_HB   = 6'b000001;
   localparam logic [ADDR_W-1:0] ADDR_REP  = 6'b111111;
   localparam logic [ADDR_W-1:0] ADDR_SAMP = 6'b111110;
   localparam logic [ADDR_W-1:0] ADDR_HOPS = 6'b111101;

   // Pending-vector bit indices; a lower index means higher priority.
   localparam int SRC_DONE = 0;
   localparam int SRC_REP  = 1;
   localparam int SRC_SAMP = 2;
   localparam int SRC_HOPS = 3;
   localparam int SRC_HB   = 4;
   localparam int NUM_SRC  = 5;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_ACK = 1'b1
   } tx_state_e;

   function automatic logic [WORD_W-1:0] pack_word(
      input logic                 flag,
      input logic [ADDR_W-1:0]    addr,
      input logic                 ctrl,
      input logic [PAYLOAD_W-1:0] payload
   );
      return {flag, addr, ctrl, payload};
   endfunction

endpackage

// File: rtl/status_tx_if.sv
// CPU-facing side of the status transmitter: GPIO word, ack toggle and status.
interface status_tx_if;
   import status_tx_pkg::*;

   logic [WORD_W-1:0] data_output;
   logic              cpu_ack_i;
   logic              busy_o;
   logic [DROP_W-1:0] drop_count_o;

   modport master (
      output data_output,
      output busy_o,
      output drop_count_o,
      input  cpu_ack_i
   );

   modport slave (
      input  data_output,
      input  busy_o,
      input  drop_count_o,
      output cpu_ack_i
   );

endinterface

// File: rtl/status_tx_sync_2ff.sv
// Single-bit two-flop synchroniser for signals arriving from another clock domain.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/status_tx.sv
// FPGA->CPU status word transmitter: run-done reports, config echoes and a heartbeat,
// sent one at a time over a toggle-flag handshake with an ack timeout.
module status_tx
   import status_tx_pkg::*;
#(
   parameter int unsigned HEARTBEAT_CYCLES = 125_000_000,
   parameter int unsigned ACK_TIMEOUT      = 1_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 done_i,
   input  logic [PAYLOAD_W-1:0] rep_count_i,
   input  logic [PAYLOAD_W-1:0] repetitions_i,
   input  logic [PAYLOAD_W-1:0] samples_i,
   input  logic [PAYLOAD_W-1:0] generator_hops_i,
   status_tx_if.master          cpu
);

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == {DROP_W{1'b1}}) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
   endfunction

   logic                 ack_s;

   tx_state_e            state_q, state_d;
   logic [WORD_W-1:0]    data_q, data_d;
   logic [31:0]          to_cnt_q, to_cnt_d;
   logic [DROP_W-1:0]    drop_q, drop_d;

   logic [NUM_SRC-1:0]   pend_q, pend_d;
   logic [NUM_SRC-1:0]   pend_set;
   logic [NUM_SRC-1:0]   pend_clr;
   logic [NUM_SRC-1:0]   grant;

   logic [PAYLOAD_W-1:0] rep_sh_q, samp_sh_q, hops_sh_q;
   logic [PAYLOAD_W-1:0] done_pl_q, done_pl_d;

   logic [31:0]          hb_tmr_q, hb_tmr_d;
   logic [PAYLOAD_W-1:0] hb_seq_q, hb_seq_d;
   logic                 hb_wrap;

   logic [ADDR_W-1:0]    sel_addr;
   logic                 sel_ctrl;
   logic [PAYLOAD_W-1:0] sel_pl;

   sync_2ff u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (cpu.cpu_ack_i),
      .q_o   (ack_s)
   );

   // Heartbeat timer; a zero period parks it and never raises a heartbeat.
   always_comb begin
      hb_tmr_d = hb_tmr_q;
      hb_wrap  = 1'b0;
      if (HEARTBEAT_CYCLES != 0) begin
         if (hb_tmr_q == HEARTBEAT_CYCLES - 1) begin
            hb_tmr_d = '0;
            hb_wrap  = 1'b1;
         end else begin
            hb_tmr_d = hb_tmr_q + 32'd1;
         end
      end
   end

   always_comb begin
      pend_set           = '0;
      pend_set[SRC_DONE] = done_i;
      pend_set[SRC_REP]  = (repetitions_i != rep_sh_q);
      pend_set[SRC_SAMP] = (samples_i != samp_sh_q);
      pend_set[SRC_HOPS] = (generator_hops_i != hops_sh_q);
      pend_set[SRC_HB]   = hb_wrap;

      done_pl_d = done_i ? rep_count_i : done_pl_q;
   end

   always_comb begin
      grant    = '0;
      sel_addr = ADDR_DONE;
      sel_ctrl = 1'b0;
      sel_pl   = '0;
      if (pend_q[SRC_DONE]) begin
         grant[SRC_DONE] = 1'b1;
         sel_addr        = ADDR_DONE;
         sel_ctrl        = 1'b1;
         sel_pl          = done_pl_q;
      end else if (pend_q[SRC_REP]) begin
         grant[SRC_REP]  = 1'b1;
         sel_addr        = ADDR_REP;
         sel_pl          = repetitions_i;
      end else if (pend_q[SRC_SAMP]) begin
         grant[SRC_SAMP] = 1'b1;
         sel_addr        = ADDR_SAMP;
         sel_pl          = samples_i;
      end else if (pend_q[SRC_HOPS]) begin
         grant[SRC_HOPS] = 1'b1;
         sel_addr        = ADDR_HOPS;
         sel_pl          = generator_hops_i;
      end else if (pend_q[SRC_HB]) begin
         grant[SRC_HB]   = 1'b1;
         sel_addr        = ADDR_HB;
         sel_pl          = hb_seq_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      to_cnt_d = to_cnt_q;
      drop_d   = drop_q;
      pend_clr = '0;
      case (state_q)
         ST_IDLE: begin
            if (|pend_q) begin
               data_d   = pack_word(~data_q[FLAG_BIT], sel_addr, sel_ctrl, sel_pl);
               pend_clr = grant;
               to_cnt_d = '0;
               state_d  = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // Ack is checked first so a late ack on the timeout cycle is not counted as a drop.
            if (ack_s == data_q[FLAG_BIT]) begin
               state_d = ST_IDLE;
            end else if ((ACK_TIMEOUT != 0) && (to_cnt_q == ACK_TIMEOUT - 1)) begin
               drop_d  = sat_inc(drop_q);
               state_d = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A new event for the source being loaded keeps it pending for a later word.
      pend_d   = (pend_q & ~pend_clr) | pend_set;
      hb_seq_d = pend_clr[SRC_HB] ? hb_seq_q + 24'd1 : hb_seq_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         to_cnt_q  <= '0;
         drop_q    <= '0;
         pend_q    <= '0;
         rep_sh_q  <= '0;
         samp_sh_q <= '0;
         hops_sh_q <= '0;
         done_pl_q <= '0;
         hb_tmr_q  <= '0;
         hb_seq_q  <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         to_cnt_q  <= to_cnt_d;
         drop_q    <= drop_d;
         pend_q    <= pend_d;
         rep_sh_q  <= repetitions_i;
         samp_sh_q <= samples_i;
         hops_sh_q <= generator_hops_i;
         done_pl_q <= done_pl_d;
         hb_tmr_q  <= hb_tmr_d;
         hb_seq_q  <= hb_seq_d;
      end
   end

   assign cpu.data_output  = data_q;
   assign cpu.busy_o       = (state_q == ST_WAIT_ACK);
   assign cpu.drop_count_o = drop_q;

endmodule

// File: tb/tb_status_tx.sv
// Scoreboard bench for status_tx: one instance with heartbeat off and a short ack
// timeout, a second with a short heartbeat period and no timeout.
module tb_status_tx;
   import status_tx_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     = 1'b1;
   logic        rst_hb_n  = 1'b1;
   logic        done      = 1'b0;
   logic        done_hb   = 1'b0;
   logic [23:0] rep_count = '0;
   logic [23:0] rep_hb    = '0;
   logic [23:0] reps      = '0;
   logic [23:0] samps     = '0;
   logic [23:0] hops      = '0;
   logic [23:0] zero24    = '0;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] exp_q[$];
   logic [31:0] hb_q[$];
   logic [31:0] prev_m = '0;
   logic [31:0] prev_h = '0;

   status_tx_if mif ();
   status_tx_if hif ();

   status_tx #(.HEARTBEAT_CYCLES(0), .ACK_TIMEOUT(16)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .done_i           (done),
      .rep_count_i      (rep_count),
      .repetitions_i    (reps),
      .samples_i        (samps),
      .generator_hops_i (hops),
      .cpu              (mif)
   );

   status_tx #(.HEARTBEAT_CYCLES(40), .ACK_TIMEOUT(0)) u_hb (
      .clk              (clk),
      .rst_n            (rst_hb_n),
      .done_i           (done_hb),
      .rep_count_i      (rep_hb),
      .repetitions_i    (zero24),
      .samples_i        (zero24),
      .generator_hops_i (zero24),
      .cpu              (hif)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy(input bit hb, input logic want, input string tag);
      logic b;
      b = hb ? hif.busy_o : mif.busy_o;
      for (int i = 0; i < 60 && b !== want; i++) begin
         tick();
         b = hb ? hif.busy_o : mif.busy_o;
      end
      chk(tag, {31'd0, b}, {31'd0, want});
   endtask

   // Behaves as the CPU: waits for a word, acks it with its flag, waits for release.
   task automatic ack_word(input bit hb, input string tag);
      wait_busy(hb, 1'b1, {tag, "_busy"});
      if (hb) hif.cpu_ack_i = hif.data_output[FLAG_BIT];
      else    mif.cpu_ack_i = mif.data_output[FLAG_BIT];
      wait_busy(hb, 1'b0, {tag, "_ack"});
   endtask

   always @(negedge clk) begin
      if (!rst_n) prev_m = '0;
      else if (mif.data_output !== prev_m) begin
         if (exp_q.size() == 0) chk("m_unexpected", mif.data_output, prev_m);
         else chk("m_word", mif.data_output, exp_q.pop_front());
         prev_m = mif.data_output;
      end
   end

   always @(negedge clk) begin
      if (!rst_hb_n) prev_h = '0;
      else if (hif.data_output !== prev_h) begin
         if (hb_q.size() == 0) chk("h_unexpected", hif.data_output, prev_h);
         else chk("h_word", hif.data_output, hb_q.pop_front());
         prev_h = hif.data_output;
      end
   end

   initial begin
      mif.cpu_ack_i = 1'b0;
      hif.cpu_ack_i = 1'b0;
      #2;
      rst_n    = 1'b0;
      rst_hb_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_data", mif.data_output, 32'h0);
      chk("rst_busy", {31'd0, mif.busy_o}, 32'h0);
      chk("rst_drop", {24'd0, mif.drop_count_o}, 32'h0);
      chk("rst_hb_data", hif.data_output, 32'h0);
      repeat (50) tick();
      chk("quiet_data", mif.data_output, 32'h0);
      chk("quiet_busy", {31'd0, mif.busy_o}, 32'h0);

      // Run done: word visible after the edge following the sampling edge.
      exp_q.push_back(32'h81000123);
      done = 1'b1; rep_count = 24'h000123;
      tick();
      done = 1'b0;
      tick();
      chk("done_latency", mif.data_output, 32'h81000123);
      chk("done_busy", {31'd0, mif.busy_o}, 32'h1);
      mif.cpu_ack_i = 1'b1;
      wait_busy(1'b0, 1'b0, "done_ack");

      // Two config changes in one cycle: REP then SAMP.
      exp_q.push_back(32'h7E0003E8);
      exp_q.push_back(32'hFC000040);
      reps = 24'd1000; samps = 24'd64;
      ack_word(1'b0, "rep");
      ack_word(1'b0, "samp");

      // DONE outranks HOPS raised in the same cycle.
      exp_q.push_back(32'h01000055);
      exp_q.push_back(32'hFA000007);
      done = 1'b1; rep_count = 24'h000055; hops = 24'd7;
      tick();
      done = 1'b0;
      ack_word(1'b0, "prio_done");
      ack_word(1'b0, "prio_hops");

      // Two done pulses while busy collapse into one DONE word with the later count.
      exp_q.push_back(32'h7E0007D0);
      exp_q.push_back(32'h81000BBB);
      reps = 24'd2000;
      wait_busy(1'b0, 1'b1, "ovw_busy");
      done = 1'b1; rep_count = 24'h000AAA;
      tick();
      rep_count = 24'h000BBB;
      tick();
      done = 1'b0;
      ack_word(1'b0, "ovw_rep");
      ack_word(1'b0, "ovw_done");

      // Unacknowledged words time out and are counted as drops.
      exp_q.push_back(32'h7C000041);
      samps = 24'd65;
      wait_busy(1'b0, 1'b1, "to1_busy");
      wait_busy(1'b0, 1'b0, "to1_drop");
      chk("to1_count", {24'd0, mif.drop_count_o}, 32'd1);
      chk("to1_hold", mif.data_output, 32'h7C000041);
      mif.cpu_ack_i = 1'b0;
      repeat (4) tick();
      exp_q.push_back(32'hFA000008);
      hops = 24'd8;
      wait_busy(1'b0, 1'b1, "to2_busy");
      wait_busy(1'b0, 1'b0, "to2_drop");
      chk("to2_count", {24'd0, mif.drop_count_o}, 32'd2);
      mif.cpu_ack_i = 1'b1;
      repeat (4) tick();
      exp_q.push_back(32'h01000007);
      done = 1'b1; rep_count = 24'h000007;
      tick();
      done = 1'b0;
      wait_busy(1'b0, 1'b1, "to3_busy");
      wait_busy(1'b0, 1'b0, "to3_drop");
      chk("to3_count", {24'd0, mif.drop_count_o}, 32'd3);
      chk("to3_hold", mif.data_output, 32'h01000007);

      // Reset while a word is in flight and another is pending.
      mif.cpu_ack_i = 1'b0;
      repeat (4) tick();
      exp_q.push_back(32'hFE000BB8);
      exp_q.push_back(32'h7C000064);
      reps = 24'd3000; samps = 24'd100;
      wait_busy(1'b0, 1'b1, "mid_busy");
      tick();
      exp_q.delete();
      #2;
      rst_n = 1'b0;
      reps = '0; samps = '0; hops = '0; rep_count = '0;
      #1;
      chk("mid_rst_data", mif.data_output, 32'h0);
      chk("mid_rst_busy", {31'd0, mif.busy_o}, 32'h0);
      chk("mid_rst_drop", {24'd0, mif.drop_count_o}, 32'h0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("post_rst_data", mif.data_output, 32'h0);
      chk("post_rst_busy", {31'd0, mif.busy_o}, 32'h0);

      // Heartbeat instance: done pulse sampled on the same edge the timer wraps.
      @(posedge clk);
      #1;
      rst_hb_n = 1'b1;
      repeat (39) tick();
      hb_q.push_back(32'h81000042);
      hb_q.push_back(32'h02000000);
      done_hb = 1'b1; rep_hb = 24'h000042;
      tick();
      done_hb = 1'b0;
      tick();
      chk("hb_done_first", hif.data_output, 32'h81000042);
      ack_word(1'b1, "hb_done");
      ack_word(1'b1, "hb_seq0");
      hb_q.push_back(32'h82000001);
      ack_word(1'b1, "hb_seq1");
      repeat (2) tick();

      chk("m_queue_left", exp_q.size(), 32'd0);
      chk("h_queue_left", hb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
